// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with operand forwarding and load-use detection
//
// Captures one decoded instruction per cycle and presents resolved ALU operands
// on the following cycle.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   stall, flush                  pipeline controller requests (flush wins)
//   id_*                          decoded instruction from the ID stage
//   exm_wen/rd_addr/result        EX/MEM writeback candidate for forwarding
//   mwb_wen/rd_addr/result        MEM/WB writeback candidate for forwarding
//   alu_a, alu_b, alu_op          resolved execute-stage operands and opcode
//   ex_store_data                 forwarded rt value for stores
//   ex_rd_addr, ex_wen,
//   ex_mem_rd, ex_mem_wr,
//   ex_valid                      registered controls
//   load_use_hazard               combinational; upstream holds PC and IF/ID
module id_ex_operand_stage #(
  parameter int DSIZE  = 16,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [2:0]        id_op,
  input  logic [AWIDTH-1:0] id_rs_addr,
  input  logic [AWIDTH-1:0] id_rt_addr,
  input  logic [AWIDTH-1:0] id_rd_addr,
  input  logic [DSIZE-1:0]  id_rs_data,
  input  logic [DSIZE-1:0]  id_rt_data,
  input  logic [DSIZE-1:0]  id_imm,
  input  logic              id_use_imm,
  input  logic              id_rt_used,
  input  logic              id_wen,
  input  logic              id_mem_rd,
  input  logic              id_mem_wr,
  input  logic              exm_wen,
  input  logic [AWIDTH-1:0] exm_rd_addr,
  input  logic [DSIZE-1:0]  exm_result,
  input  logic              mwb_wen,
  input  logic [AWIDTH-1:0] mwb_rd_addr,
  input  logic [DSIZE-1:0]  mwb_result,
  output logic [DSIZE-1:0]  alu_a,
  output logic [DSIZE-1:0]  alu_b,
  output logic [2:0]        alu_op,
  output logic [DSIZE-1:0]  ex_store_data,
  output logic [AWIDTH-1:0] ex_rd_addr,
  output logic              ex_wen,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic              ex_valid,
  output logic              load_use_hazard
);

  logic [AWIDTH-1:0] rs_addr_q;
  logic [AWIDTH-1:0] rt_addr_q;
  logic [DSIZE-1:0]  rs_data_q;
  logic [DSIZE-1:0]  rt_data_q;
  logic [DSIZE-1:0]  imm_q;
  logic              use_imm_q;
  logic [DSIZE-1:0]  rs_fwd;
  logic [DSIZE-1:0]  rt_fwd;
  logic              bubble;

  // A load in EX cannot supply its data until it reaches MEM/WB, so a
  // dependent instruction in ID must wait one cycle behind a bubble.
  always_comb begin
    load_use_hazard = ex_valid && ex_mem_rd && (ex_rd_addr != '0) && id_valid &&
                      ((id_rs_addr == ex_rd_addr) ||
                       (id_rt_used && (id_rt_addr == ex_rd_addr)));
  end

  // The hazard only inserts a bubble when the controller is not already
  // stalling; under stall the held load must stay in EX.
  assign bubble = flush || (load_use_hazard && !stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op     <= '0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      ex_rd_addr <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      use_imm_q  <= 1'b0;
      ex_wen     <= 1'b0;
      ex_mem_rd  <= 1'b0;
      ex_mem_wr  <= 1'b0;
      ex_valid   <= 1'b0;
    end else if (bubble) begin
      alu_op     <= '0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      ex_rd_addr <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      use_imm_q  <= 1'b0;
      ex_wen     <= 1'b0;
      ex_mem_rd  <= 1'b0;
      ex_mem_wr  <= 1'b0;
      ex_valid   <= 1'b0;
    end else if (!stall) begin
      alu_op     <= id_op;
      rs_addr_q  <= id_rs_addr;
      rt_addr_q  <= id_rt_addr;
      ex_rd_addr <= id_rd_addr;
      rs_data_q  <= id_rs_data;
      rt_data_q  <= id_rt_data;
      imm_q      <= id_imm;
      use_imm_q  <= id_use_imm;
      ex_wen     <= id_wen & id_valid;
      ex_mem_rd  <= id_mem_rd & id_valid;
      ex_mem_wr  <= id_mem_wr & id_valid;
      ex_valid   <= id_valid;
    end
  end

  // Youngest result wins: EX/MEM before MEM/WB before register file.
  // Register 0 is hard-wired zero and never takes a forwarded value.
  always_comb begin
    rs_fwd = rs_data_q;
    if (exm_wen && (exm_rd_addr == rs_addr_q) && (rs_addr_q != '0))
      rs_fwd = exm_result;
    else if (mwb_wen && (mwb_rd_addr == rs_addr_q) && (rs_addr_q != '0))
      rs_fwd = mwb_result;

    rt_fwd = rt_data_q;
    if (exm_wen && (exm_rd_addr == rt_addr_q) && (rt_addr_q != '0))
      rt_fwd = exm_result;
    else if (mwb_wen && (mwb_rd_addr == rt_addr_q) && (rt_addr_q != '0))
      rt_fwd = mwb_result;
  end

  // Operands are zeroed for bubbles so the ALU never sees stale forwarded data.
  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    ex_store_data = '0;
    if (ex_valid) begin
      alu_a         = rs_fwd;
      alu_b         = use_imm_q ? imm_q : rt_fwd;
      ex_store_data = rt_fwd;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - scoreboard bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [2:0]  id_op = '0;
  logic [3:0]  id_rs_addr = '0;
  logic [3:0]  id_rt_addr = '0;
  logic [3:0]  id_rd_addr = '0;
  logic [15:0] id_rs_data = '0;
  logic [15:0] id_rt_data = '0;
  logic [15:0] id_imm = '0;
  logic        id_use_imm = 1'b0;
  logic        id_rt_used = 1'b0;
  logic        id_wen = 1'b0;
  logic        id_mem_rd = 1'b0;
  logic        id_mem_wr = 1'b0;
  logic        exm_wen = 1'b0;
  logic [3:0]  exm_rd_addr = '0;
  logic [15:0] exm_result = '0;
  logic        mwb_wen = 1'b0;
  logic [3:0]  mwb_rd_addr = '0;
  logic [15:0] mwb_result = '0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] ex_store_data;
  logic [3:0]  ex_rd_addr;
  logic        ex_wen;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic        ex_valid;
  logic        load_use_hazard;

  id_ex_operand_stage #(.DSIZE(16), .AWIDTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_op(id_op),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_rt_used(id_rt_used),
    .id_wen(id_wen), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
    .exm_wen(exm_wen), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
    .mwb_wen(mwb_wen), .mwb_rd_addr(mwb_rd_addr), .mwb_result(mwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
    .ex_rd_addr(ex_rd_addr), .ex_wen(ex_wen), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_valid(ex_valid), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [59:0] v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // {alu_a, alu_b, store, op, rd, valid, wen, mem_rd, mem_wr, hazard}
  function automatic logic [59:0] exv(input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] sd, input logic [2:0] op,
                                      input logic [3:0] rd, input logic v, input logic w,
                                      input logic mr, input logic mw, input logic h);
    return {a, b, sd, op, rd, v, w, mr, mw, h};
  endfunction

  task automatic expect_out(input string nm, input logic [59:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [2:0] op, input logic [3:0] rs,
                        input logic [3:0] rt, input logic [3:0] rd,
                        input logic [15:0] rsd, input logic [15:0] rtd,
                        input logic [15:0] imm, input logic ui, input logic ru,
                        input logic w, input logic mr, input logic mw);
    id_valid = v; id_op = op; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_use_imm = ui;
    id_rt_used = ru; id_wen = w; id_mem_rd = mr; id_mem_wr = mw;
  endtask

  // Monitor: outputs settle after the posedge+1 stimulus, sampled at negedge.
  always @(negedge clk) begin
    logic [59:0] act;
    exp_t        e;
    act = {alu_a, alu_b, ex_store_data, alu_op, ex_rd_addr,
           ex_valid, ex_wen, ex_mem_rd, ex_mem_wr, load_use_hazard};
    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.nm, act, e.v);
      end
    end
  end

  initial begin
    step();
    expect_out("reset_state", exv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    rst = 1'b0;
    id_set(1, OP_ADD, 1, 2, 3, 16'd5, 16'd7, 0, 0, 1, 1, 0, 0);
    expect_out("post_reset_idle", exv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    expect_out("add_basic", exv(16'd5, 16'd7, 16'd7, OP_ADD, 3, 1, 1, 0, 0, 0));
    step();
    #1 rst = 1'b1;
    expect_out("async_reset", exv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    rst = 1'b0;

    // Forward priority on rs
    id_set(1, OP_ADD, 3, 0, 6, 16'h0100, 16'h0000, 16'h0002, 1, 0, 1, 0, 0);
    step();
    exm_wen = 1; exm_rd_addr = 3; exm_result = 16'h0011;
    mwb_wen = 1; mwb_rd_addr = 3; mwb_result = 16'h0022;
    expect_out("fwd_exm_wins", exv(16'h0011, 16'h0002, 0, OP_ADD, 6, 1, 1, 0, 0, 0));
    step();
    exm_wen = 0;
    expect_out("fwd_mwb", exv(16'h0022, 16'h0002, 0, OP_ADD, 6, 1, 1, 0, 0, 0));
    step();
    mwb_wen = 0;
    expect_out("fwd_none", exv(16'h0100, 16'h0002, 0, OP_ADD, 6, 1, 1, 0, 0, 0));

    // Register 0 never forwards
    step();
    id_set(1, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    exm_wen = 1; exm_rd_addr = 0; exm_result = 16'hFFFF;
    mwb_wen = 1; mwb_rd_addr = 0; mwb_result = 16'hEEEE;
    expect_out("reg0_no_fwd", exv(0, 0, 0, OP_ADD, 0, 1, 0, 0, 0, 0));

    // Load-use on rs
    step();
    exm_wen = 0; mwb_wen = 0;
    id_set(1, OP_ADD, 1, 0, 4, 16'h0010, 0, 16'd4, 1, 0, 1, 1, 0);
    step();
    id_set(1, OP_ADD, 4, 2, 5, 16'h0077, 16'h0003, 0, 0, 1, 1, 0, 0);
    expect_out("lu_hazard", exv(16'h0010, 16'd4, 0, OP_ADD, 4, 1, 1, 1, 0, 1));
    step();
    expect_out("lu_bubble", exv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    mwb_wen = 1; mwb_rd_addr = 4; mwb_result = 16'd9;
    step();
    expect_out("lu_fwd_mwb", exv(16'd9, 16'd3, 16'd3, OP_ADD, 5, 1, 1, 0, 0, 0));

    // Load-use on rt, held by stall, then rt_used drops
    step();
    mwb_wen = 0;
    id_set(1, OP_ADD, 1, 0, 4, 16'h0010, 0, 16'd4, 1, 0, 1, 1, 0);
    step();
    id_set(1, OP_ADD, 1, 4, 6, 16'h0010, 16'h0044, 0, 0, 1, 1, 0, 0);
    stall = 1;
    expect_out("lu_rt_hazard", exv(16'h0010, 16'd4, 0, OP_ADD, 4, 1, 1, 1, 0, 1));
    step();
    id_rt_used = 0;
    expect_out("lu_rt_unused", exv(16'h0010, 16'd4, 0, OP_ADD, 4, 1, 1, 1, 0, 0));

    // SW store data forwarding
    stall = 0;
    id_set(1, OP_ADD, 1, 5, 0, 16'h0010, 16'h0055, 16'd8, 1, 1, 0, 0, 1);
    step();
    exm_wen = 1; exm_rd_addr = 5; exm_result = 16'h1234;
    expect_out("sw_store", exv(16'h0010, 16'd8, 16'h1234, OP_ADD, 0, 1, 0, 0, 1, 0));

    // Stall for three cycles, then stall+flush
    stall = 1;
    id_set(1, OP_OR, 2, 3, 7, 16'hAAAA, 16'hBBBB, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("stall_hold%0d", i),
                 exv(16'h0010, 16'd8, 16'h1234, OP_ADD, 0, 1, 0, 0, 1, 0));
    end
    flush = 1;
    step();
    expect_out("stall_flush", exv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Flush during a load-use cycle gives one bubble
    flush = 0; stall = 0; exm_wen = 0;
    id_set(1, OP_ADD, 1, 0, 4, 16'h0010, 0, 16'd4, 1, 0, 1, 1, 0);
    step();
    id_set(1, OP_ADD, 4, 2, 5, 16'h0077, 16'h0003, 0, 0, 1, 1, 0, 0);
    flush = 1;
    expect_out("flush_lu_hazard", exv(16'h0010, 16'd4, 0, OP_ADD, 4, 1, 1, 1, 0, 1));
    step();
    flush = 0;
    id_valid = 0;
    expect_out("flush_lu_bubble", exv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    step();
    step();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
